// File: rtl/iir_pkg.sv
// Shared types, constants and the round/saturate helper for the biquad cascade.
package iir_pkg;

  localparam int NTAP     = 5;
  localparam int CYC_SECT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CS_B0 = 3'd0,
    CS_B1 = 3'd1,
    CS_B2 = 3'd2,
    CS_A1 = 3'd3,
    CS_A2 = 3'd4
  } coef_sel_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } sr_t;

  // Round half up, arithmetic shift, clamp to a signed data_w range.
  function automatic sr_t sat_round(input logic signed [63:0] acc,
                                    input int frac_w, input int data_w);
    logic signed [63:0] r, hi, lo;
    sr_t o;
    r     = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi    = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (data_w - 1));
    o.sat = (r > hi) || (r < lo);
    o.val = (r > hi) ? hi : ((r < lo) ? lo : r);
    return o;
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_mac.sv
// Shared multiply-accumulate: load/accumulate/subtract, rounded and saturated view.
module iir_mac
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_ld,
  input  logic                     i_sub,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [COEF_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_sat
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         prod_x, acc;
  sr_t                             r;

  assign prod   = i_a * i_b;
  assign prod_x = ACC_W'(prod);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)  acc <= '0;
    else if (i_en) begin
      if (i_ld) acc <= i_sub ? -prod_x : prod_x;
      else      acc <= i_sub ? acc - prod_x : acc + prod_x;
    end
  end

  assign r     = sat_round(64'(acc), FRAC_W, DATA_W);
  assign o_y   = DATA_W'(r.val);
  assign o_sat = r.sat;

endmodule

// File: rtl/iir_biquad_cascade.sv
// Time-multiplexed DF-I biquad cascade over N_CH channels sharing one MAC.
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 18,
  parameter int FRAC_W = 16,
  parameter int N_SECT = 4,
  parameter int N_CH   = 2,
  parameter int ACC_W  = 40
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic                       i_start,
  input  logic [N_CH*DATA_W-1:0]     i_x,
  input  logic                       i_coef_we,
  input  logic [$clog2(N_SECT)-1:0]  i_coef_sect,
  input  logic [2:0]                 i_coef_sel,
  input  logic [COEF_W-1:0]          i_coef_data,
  output logic [N_CH*DATA_W-1:0]     o_y,
  output logic                       o_done,
  output logic                       o_busy,
  output logic                       o_sat,
  output logic                       o_overrun
);

  localparam int SW = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic signed [COEF_W-1:0] ONE = COEF_W'(1 << FRAC_W);

  state_e                           state;
  logic [2:0]                       tap;
  logic [SW-1:0]                    sect;
  logic [CW-1:0]                    ch;
  logic signed [DATA_W-1:0]         cur_x;
  logic [N_CH-1:0][DATA_W-1:0]      x_lat, y_buf;
  logic                             sat_fr, accept;
  logic signed [COEF_W-1:0]         coef_sh [N_SECT][NTAP];
  logic signed [COEF_W-1:0]         coef_sh_nxt [N_SECT][NTAP];
  logic signed [COEF_W-1:0]         coef_act [N_SECT][NTAP];
  logic signed [DATA_W-1:0]         hx1 [N_CH][N_SECT], hx2 [N_CH][N_SECT];
  logic signed [DATA_W-1:0]         hy1 [N_CH][N_SECT], hy2 [N_CH][N_SECT];
  logic signed [DATA_W-1:0]         mac_a, mac_y;
  logic signed [COEF_W-1:0]         mac_b;
  logic                             mac_sub, mac_sat;

  assign accept = i_valid && i_start && (state == ST_IDLE);
  assign o_busy = (state != ST_IDLE);

  // A write landing in the same cycle as an accepted start joins the copy.
  always_comb begin
    coef_sh_nxt = coef_sh;
    if (i_coef_we && i_coef_sel < 3'd5 && int'(i_coef_sect) < N_SECT)
      coef_sh_nxt[i_coef_sect][i_coef_sel] = i_coef_data;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < N_SECT; s++)
        for (int t = 0; t < NTAP; t++) begin
          coef_sh[s][t]  <= (t == 0) ? ONE : '0;
          coef_act[s][t] <= (t == 0) ? ONE : '0;
        end
    end else begin
      coef_sh <= coef_sh_nxt;
      if (accept) coef_act <= coef_sh_nxt;
    end
  end

  always_comb begin
    mac_a   = cur_x;
    mac_b   = coef_act[sect][CS_B0];
    mac_sub = 1'b0;
    case (tap)
      CS_B1: begin mac_a = hx1[ch][sect]; mac_b = coef_act[sect][CS_B1]; end
      CS_B2: begin mac_a = hx2[ch][sect]; mac_b = coef_act[sect][CS_B2]; end
      CS_A1: begin mac_a = hy1[ch][sect]; mac_b = coef_act[sect][CS_A1]; mac_sub = 1'b1; end
      CS_A2: begin mac_a = hy2[ch][sect]; mac_b = coef_act[sect][CS_A2]; mac_sub = 1'b1; end
      default: ;
    endcase
  end

  iir_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_valid && state == ST_MAC),
    .i_ld   (tap == 3'd0),
    .i_sub  (mac_sub),
    .i_a    (mac_a),
    .i_b    (mac_b),
    .o_y    (mac_y),
    .o_sat  (mac_sat)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_SECT; s++) begin
          hx1[c][s] <= '0; hx2[c][s] <= '0; hy1[c][s] <= '0; hy2[c][s] <= '0;
        end
    end else if (!i_valid) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_SECT; s++) begin
          hx1[c][s] <= '0; hx2[c][s] <= '0; hy1[c][s] <= '0; hy2[c][s] <= '0;
        end
    end else if (state == ST_WB) begin
      hx2[ch][sect] <= hx1[ch][sect];
      hx1[ch][sect] <= cur_x;
      hy2[ch][sect] <= hy1[ch][sect];
      hy1[ch][sect] <= mac_y;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE; tap <= '0; sect <= '0; ch <= '0; cur_x <= '0;
      x_lat <= '0; y_buf <= '0; sat_fr <= 1'b0;
      o_y <= '0; o_done <= 1'b0; o_sat <= 1'b0; o_overrun <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      if (!i_valid) begin
        state <= ST_IDLE;
        o_y   <= '0;
        o_sat <= 1'b0;
      end else begin
        if (i_start && state != ST_IDLE) o_overrun <= 1'b1;
        case (state)
          ST_IDLE: if (i_start) begin
            state <= ST_MAC; tap <= '0; sect <= '0; ch <= '0;
            x_lat <= i_x; cur_x <= i_x[DATA_W-1:0]; sat_fr <= 1'b0;
          end
          ST_MAC: begin
            tap <= tap + 3'd1;
            if (tap == 3'(NTAP - 1)) state <= ST_WB;
          end
          ST_WB: begin
            sat_fr <= sat_fr | mac_sat;
            tap    <= '0;
            if (sect == SW'(N_SECT - 1)) begin
              y_buf[ch] <= mac_y;
              sect      <= '0;
              if (ch == CW'(N_CH - 1)) state <= ST_DONE;
              else begin
                ch    <= ch + CW'(1);
                cur_x <= x_lat[ch + CW'(1)];
                state <= ST_MAC;
              end
            end else begin
              sect  <= sect + SW'(1);
              cur_x <= mac_y;
              state <= ST_MAC;
            end
          end
          ST_DONE: begin
            o_y    <= y_buf;
            o_sat  <= sat_fr;
            o_done <= 1'b1;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: spec vector table, corner sequences, random frames vs a frame-level model.
module tb_iir_biquad_cascade;

  localparam int DW = 16, NS = 4, NC = 2, F = 16;

  logic              clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_start = 1'b0, i_coef_we = 1'b0;
  logic [NC*DW-1:0]  i_x = '0;
  logic [1:0]        i_coef_sect = '0;
  logic [2:0]        i_coef_sel = '0;
  logic [17:0]       i_coef_data = '0;
  logic [NC*DW-1:0]  o_y;
  logic              o_done, o_busy, o_sat, o_overrun;

  int total = 0, bad = 0;

  longint m_sh [NS][5], m_act [NS][5];
  longint hx1 [NC][NS], hx2 [NC][NS], hy1 [NC][NS], hy2 [NC][NS];

  iir_biquad_cascade dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_start(i_start), .i_x(i_x),
    .i_coef_we(i_coef_we), .i_coef_sect(i_coef_sect), .i_coef_sel(i_coef_sel),
    .i_coef_data(i_coef_data), .o_y(o_y), .o_done(o_done), .o_busy(o_busy),
    .o_sat(o_sat), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  function automatic longint ych(input int c);
    return longint'($signed(o_y[c*DW +: DW]));
  endfunction

  task automatic model_clear_hist();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < NS; s++) begin
        hx1[c][s] = 0; hx2[c][s] = 0; hy1[c][s] = 0; hy2[c][s] = 0;
      end
  endtask

  // Whole-frame reference: each channel runs through every section in order.
  task automatic model_frame(input longint x0, input longint x1,
                             output longint y0, output longint y1, output bit sat);
    longint xs [NC];
    longint v, acc, r;
    xs[0] = x0; xs[1] = x1; sat = 0;
    for (int c = 0; c < NC; c++) begin
      v = xs[c];
      for (int s = 0; s < NS; s++) begin
        acc = m_act[s][0]*v + m_act[s][1]*hx1[c][s] + m_act[s][2]*hx2[c][s]
            - m_act[s][3]*hy1[c][s] - m_act[s][4]*hy2[c][s];
        r = (acc + 32768) >>> F;
        if (r > 32767)  begin r = 32767;  sat = 1; end
        if (r < -32768) begin r = -32768; sat = 1; end
        hx2[c][s] = hx1[c][s]; hx1[c][s] = v;
        hy2[c][s] = hy1[c][s]; hy1[c][s] = r;
        v = r;
      end
      xs[c] = v;
    end
    y0 = xs[0]; y1 = xs[1];
  endtask

  task automatic wr_coef(input int s, input int sel, input longint d);
    i_coef_we = 1'b1; i_coef_sect = s[1:0]; i_coef_sel = sel[2:0]; i_coef_data = d[17:0];
    @(negedge clk);
    i_coef_we = 1'b0;
    if (sel < 5) m_sh[s][sel] = d;
  endtask

  task automatic wait_done(inout int cnt);
    while (!o_done && cnt < 200) begin @(negedge clk); cnt++; end
  endtask

  // Entered and left at a negedge; the start is accepted at the next posedge.
  task automatic run_frame(input longint x0, input longint x1,
                           output longint g0, output longint g1, output bit gs);
    longint e0, e1; bit es; int cnt;
    i_x = {x1[15:0], x0[15:0]}; i_start = 1'b1;
    m_act = m_sh;
    model_frame(x0, x1, e0, e1, es);
    @(negedge clk);
    i_start = 1'b0; cnt = 0;
    chk("busy_start", o_busy, 1);
    wait_done(cnt);
    chk("done_latency", cnt, 49);
    chk("busy_end", o_busy, 0);
    g0 = ych(0); g1 = ych(1); gs = o_sat;
    chk("y0_model", g0, e0);
    chk("y1_model", g1, e1);
    chk("sat_model", gs, es);
  endtask

  task automatic impulse(input string tag);
    longint g0, g1; bit gs;
    for (int k = 0; k < 5; k++) begin
      run_frame(k == 0 ? 16000 : 0, k == 0 ? -16000 : 0, g0, g1, gs);
      chk({tag, "_ch0"}, g0, 16000 >>> k);
      chk({tag, "_ch1"}, g1, -(16000 >>> k));
    end
  endtask

  typedef struct {
    bit     wr;
    int     sel;
    longint data;
    longint x0, x1, y0, y1;
    bit     sat;
  } vec_t;

  initial begin
    vec_t   tbl [5];
    longint g0, g1, e0, e1;
    bit     gs, es, seen;
    int     cnt;

    tbl[0] = '{1'b0, 0, 0,     -2000,  1000,  -2000,  1000,  1'b0};
    tbl[1] = '{1'b1, 0, 32768,  1000,  1001,    500,   501,  1'b0};
    tbl[2] = '{1'b0, 0, 0,     -1001,     3,   -500,     2,  1'b0};
    tbl[3] = '{1'b1, 0, 98304, 30000, -30000, 32767, -32768, 1'b1};
    tbl[4] = '{1'b0, 0, 0,       100,  -100,    150,  -150,  1'b0};

    for (int s = 0; s < NS; s++)
      for (int t = 0; t < 5; t++) m_sh[s][t] = (t == 0) ? 65536 : 0;
    m_act = m_sh;
    model_clear_hist();

    repeat (3) @(negedge clk);
    chk("rst_y", o_y, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_overrun", o_overrun, 0);
    i_rst_n = 1'b1; i_valid = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr_coef(0, tbl[i].sel, tbl[i].data);
      run_frame(tbl[i].x0, tbl[i].x1, g0, g1, gs);
      chk($sformatf("tbl%0d_y0", i), g0, tbl[i].y0);
      chk($sformatf("tbl%0d_y1", i), g1, tbl[i].y1);
      chk($sformatf("tbl%0d_sat", i), gs, tbl[i].sat);
    end

    // Clear history, then y = x + 0.5*y1 on section 0.
    i_valid = 1'b0; @(negedge clk); i_valid = 1'b1; model_clear_hist();
    chk("clear_y", o_y, 0);
    wr_coef(0, 0, 65536);
    wr_coef(0, 3, -32768);
    impulse("imp_a");

    // Abort a frame by dropping i_valid ahead of E20.
    i_x = {16'd500, 16'd700}; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0; cnt = 0;
    repeat (19) begin @(negedge clk); cnt++; end
    i_valid = 1'b0;
    @(negedge clk); cnt++;
    chk("abort_y", o_y, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_sat", o_sat, 0);
    i_start = 1'b1;
    @(negedge clk); cnt++; i_start = 1'b0;
    chk("abort_start_ignored", o_busy, 0);
    chk("abort_no_overrun", o_overrun, 0);
    @(negedge clk); cnt++;
    i_valid = 1'b1; seen = 0;
    while (cnt < 70) begin @(negedge clk); cnt++; if (o_done) seen = 1; end
    chk("abort_no_done", seen, 0);
    model_clear_hist();
    impulse("imp_b");

    // Start at E10 of a busy frame plus a shadow write to b0.
    i_x = {16'hFDC9, 16'd1234}; i_start = 1'b1;
    m_act = m_sh;
    model_frame(1234, -567, e0, e1, es);
    @(negedge clk); i_start = 1'b0; cnt = 0;
    repeat (9) begin @(negedge clk); cnt++; end
    i_start = 1'b1; i_coef_we = 1'b1; i_coef_sect = 2'd0; i_coef_sel = 3'd0; i_coef_data = 18'd32768;
    @(negedge clk); cnt++;
    i_start = 1'b0; i_coef_we = 1'b0; m_sh[0][0] = 32768;
    chk("overrun_pulse", o_overrun, 1);
    chk("overrun_busy", o_busy, 1);
    @(negedge clk); cnt++;
    chk("overrun_one_cycle", o_overrun, 0);
    wait_done(cnt);
    chk("overrun_latency", cnt, 49);
    chk("overrun_y0", ych(0), e0);
    chk("overrun_y1", ych(1), e1);
    run_frame(1000, 1000, g0, g1, gs);

    // Random coefficients and samples against the model.
    for (int s = 0; s < NS; s++) begin
      wr_coef(s, 0, longint'($urandom_range(0, 98303)) - 49152);
      wr_coef(s, 1, longint'($urandom_range(0, 65535)) - 32768);
      wr_coef(s, 2, longint'($urandom_range(0, 65535)) - 32768);
      wr_coef(s, 3, longint'($urandom_range(0, 52428)) - 26214);
      wr_coef(s, 4, longint'($urandom_range(0, 26214)) - 13107);
    end
    wr_coef(1, 5, 777);
    for (int n = 0; n < 8; n++) begin
      if (n == 4) wr_coef(2, 0, longint'($urandom_range(0, 131071)) - 65536);
      run_frame(longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768, g0, g1, gs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
